ram_arbiter: RTL and testbench

Two-port round-robin arbiter sharing the single-port 32×8 RAM between two requesters, e.g. the CPU datapath (port 0) and a loader/DMA port (port 1). Each requester issues a read or write with a level request and receives a one-cycle acknowledge with registered read data. The arbiter owns the RAM's `addr`, `data_in` and `we` pins and samples its `data_out`. The RAM itself is unchanged.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 22 ++
 rtl/ram_arbiter.sv | 113 +++++++++++
 tb/tb_ram_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef logic [0:0] port_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; a tie goes to the port not granted last.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  port_idx_t  last_grant,
    output logic       grant_valid,
    output port_idx_t  grant_idx
);

    always_comb begin
        grant_valid = |eligible;
        grant_idx   = 1'b0;
        case (eligible)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between two requesters: one-cycle ACCESS per grant,
// registered ack and read data per port, round-robin on contention.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    state_t            state_q;
    state_t            state_d;
    port_idx_t         last_grant_q;
    port_idx_t         grant_idx_q;
    port_idx_t         grant_idx;
    logic              grant_valid;
    logic              load;
    logic              ram_we_q;
    logic [1:0]        eligible;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    // A port acked this cycle is masked so a late-dropped req is not re-granted.
    assign eligible = {req1 & ~ack1, req0 & ~ack0};

    rr_arb2 u_rr_arb2 (
        .eligible    (eligible),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next state and winner operand select.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        we_sel    = we0;
        addr_sel  = addr0;
        wdata_sel = wdata0;
        if (grant_idx == 1'b1) begin
            we_sel    = we1;
            addr_sel  = addr1;
            wdata_sel = wdata1;
        end
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM pin registers double as the operand latches; they are zero outside ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_idx_q  <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr     <= '0;
            ram_data_in  <= '0;
            busy         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= (state_d == ACCESS);
            ram_we_q    <= load & we_sel;
            ram_addr    <= load ? addr_sel : '0;
            ram_data_in <= load ? wdata_sel : '0;
            if (load) begin
                grant_idx_q  <= grant_idx;
                last_grant_q <= grant_idx;
            end
            ack0 <= (state_q == ACCESS) && (grant_idx_q == 1'b0);
            ack1 <= (state_q == ACCESS) && (grant_idx_q == 1'b1);
            if (state_q == ACCESS && !ram_we_q) begin
                if (grant_idx_q == 1'b1) rdata1 <= ram_data_out;
                else                     rdata0 <= ram_data_out;
            end
        end
    end

    // No write may land on an edge where reset is asserted.
    assign ram_we = ram_we_q & rst_n;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural RAM, directed scenarios and a
// randomized two-requester phase checked against a transaction-level model.
module tb_ram_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, ram_we, busy;
    logic [DW-1:0] rdata0, rdata1, ram_data_in, ram_data_out;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] ram_mem [32];
    logic [DW-1:0] ref_mem [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
        .ram_data_out(ram_data_out), .busy(busy)
    );

    // The existing single-port RAM: combinational read, write on the rising edge.
    assign ram_data_out = ram_mem[ram_addr];
    always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_data_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One uncontended access: ack two cycles after req, RAM driven only in ACCESS.
    task automatic single(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        int cyc;
        logic got;
        cyc = 0;
        got = 1'b0;
        @(negedge clk);
        drive(p, 1'b1, w, a, d);
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq("acc_busy", 32'(busy), 32'd1);
                check_eq("acc_we", 32'(ram_we), 32'(w));
                check_eq("acc_addr", 32'(ram_addr), 32'(a));
            end
            got = (p == 0) ? ack0 : ack1;
        end
        check_eq("ack_latency", 32'(cyc), 32'd2);
        check_eq("ack_we_low", 32'(ram_we), 32'd0);
        drive(p, 1'b0, w, a, d);
        if (w) ref_mem[a] = d;
        else   check_eq("rd_data", 32'((p == 0) ? rdata0 : rdata1), 32'(exp_rd));
    endtask

    // Randomized-phase state: requester ops and the expected outputs.
    logic          r_req [2];
    logic          r_we  [2];
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wd  [2];
    logic [1:0]    e_ack;
    logic [DW-1:0] e_rd  [2];
    logic          e_busy, e_ram_we;
    logic [AW-1:0] e_ram_addr;
    logic          m_pending;
    int            m_idx, m_last;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;

    task automatic new_op(input int p);
        r_we[p]   = 1'($urandom % 2);
        r_addr[p] = AW'($urandom % 8);
        r_wd[p]   = DW'($urandom);
    endtask

    initial begin
        int a0, a1;
        logic [1:0] el;
        int win;

        for (int i = 0; i < 32; i++) begin
            ram_mem[i] <= DW'(i);
            ref_mem[i] = DW'(i);
        end
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Reset then idle.
        reset_dut();
        check_eq("rst_ack0", 32'(ack0), 32'd0);
        check_eq("rst_ack1", 32'(ack1), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_we", 32'(ram_we), 32'd0);
        check_eq("rst_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_rd0", 32'(rdata0), 32'd0);
        check_eq("rst_rd1", 32'(rdata1), 32'd0);

        // Single write then read on port 0.
        single(0, 1'b1, 5'd1, 8'hAA, 8'h00);
        single(0, 1'b0, 5'd1, 8'h00, 8'hAA);

        // Tie after reset: port 0 first.
        reset_dut();
        drive(0, 1'b1, 1'b1, 5'd3, 8'h11);
        drive(1, 1'b1, 1'b1, 5'd4, 8'h22);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check_eq("tie_ack0", 32'(ack0), 32'(c == 2));
            check_eq("tie_ack1", 32'(ack1), 32'(c == 4));
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        ref_mem[3] = 8'h11;
        ref_mem[4] = 8'h22;
        single(0, 1'b0, 5'd3, 8'h00, 8'h11);
        single(1, 1'b0, 5'd4, 8'h00, 8'h22);

        // Continuous contention for 16 cycles.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 5'd3, 8'h00);
        drive(1, 1'b1, 1'b0, 5'd4, 8'h00);
        a0 = 0; a1 = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check_eq("cont_ack0", 32'(ack0), 32'(c % 4 == 2));
            check_eq("cont_ack1", 32'(ack1), 32'(c % 4 == 0));
            if (ack0) begin a0++; check_eq("cont_rd0", 32'(rdata0), 32'h11); end
            if (ack1) begin a1++; check_eq("cont_rd1", 32'(rdata1), 32'h22); end
        end
        req0 = 1'b0; req1 = 1'b0;
        check_eq("cont_n0", 32'(a0), 32'd4);
        check_eq("cont_n1", 32'(a1), 32'd4);

        // Port isolation: port 0 writes while port 1 reads.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 5'd5, 8'h66);
        drive(1, 1'b1, 1'b0, 5'd4, 8'h00);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check_eq("iso_overlap", 32'(ack0 & ack1), 32'd0);
            check_eq("iso_ack0", 32'(ack0), 32'(c == 2));
            check_eq("iso_ack1", 32'(ack1), 32'(c == 4));
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        ref_mem[5] = 8'h66;
        check_eq("iso_rd1", 32'(rdata1), 32'h22);
        check_eq("iso_rd0", 32'(rdata0), 32'h11);

        // Reset during ACCESS abandons the write; the held req completes afterwards.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 5'd7, 8'h55);
        @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_we", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_we_gated", 32'(ram_we), 32'd0);
        @(negedge clk);
        check_eq("mid_no_ack", 32'(ack1), 32'd0);
        check_eq("mid_no_busy", 32'(busy), 32'd0);
        check_eq("mid_mem_kept", 32'(ram_mem[7]), 32'(ref_mem[7]));
        rst_n = 1'b1;
        a1 = 0;
        while (!ack1 && a1 < 8) begin
            @(negedge clk);
            a1++;
        end
        check_eq("mid_retry_lat", 32'(a1), 32'd2);
        req1 = 1'b0;
        ref_mem[7] = 8'h55;
        single(1, 1'b0, 5'd7, 8'h00, 8'h55);

        // Randomized phase against the transaction-level model.
        reset_dut();
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0;
            new_op(p);
            e_rd[p] = '0;
        end
        e_ack = 2'b00; e_busy = 1'b0; e_ram_we = 1'b0; e_ram_addr = '0;
        m_pending = 1'b0; m_last = 1; m_idx = 0;
        m_we = 1'b0; m_addr = '0; m_wd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check_eq("rnd_ack0", 32'(ack0), 32'(e_ack[0]));
            check_eq("rnd_ack1", 32'(ack1), 32'(e_ack[1]));
            check_eq("rnd_busy", 32'(busy), 32'(e_busy));
            check_eq("rnd_we", 32'(ram_we), 32'(e_ram_we));
            check_eq("rnd_addr", 32'(ram_addr), 32'(e_ram_addr));
            check_eq("rnd_rd0", 32'(rdata0), 32'(e_rd[0]));
            check_eq("rnd_rd1", 32'(rdata1), 32'(e_rd[1]));

            for (int p = 0; p < 2; p++) begin
                if (e_ack[p]) begin
                    r_req[p] = 1'($urandom % 2);
                    new_op(p);
                end else if (!r_req[p] && ($urandom % 3 == 0)) begin
                    r_req[p] = 1'b1;
                    new_op(p);
                end
                drive(p, r_req[p], r_we[p], r_addr[p], r_wd[p]);
            end

            if (m_pending) begin
                e_ack = 2'b00;
                e_ack[m_idx] = 1'b1;
                if (m_we) ref_mem[m_addr] = m_wd;
                else      e_rd[m_idx] = ref_mem[m_addr];
                m_pending = 1'b0;
            end else begin
                el = {r_req[1] & ~e_ack[1], r_req[0] & ~e_ack[0]};
                e_ack = 2'b00;
                if (el != 2'b00) begin
                    if (el == 2'b11) win = 1 - m_last;
                    else             win = el[1] ? 1 : 0;
                    m_last = win;
                    m_idx = win;
                    m_we = r_we[win];
                    m_addr = r_addr[win];
                    m_wd = r_wd[win];
                    m_pending = 1'b1;
                end
            end
            e_busy = m_pending;
            e_ram_we = m_pending & m_we;
            e_ram_addr = m_pending ? m_addr : '0;

            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
